// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of {pc, instr} pairs between fetch and decode.
// Full raises stall to hold the PC register; a redirect flush empties the queue.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       f_valid,
    input  logic [31:0]                f_pc,
    input  logic [31:0]                f_instr,
    output logic                       stall,
    input  logic                       flush,
    input  logic                       d_ready,
    output logic                       d_valid,
    output logic [31:0]                d_pc,
    output logic [31:0]                d_instr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] rp;
    logic [AW-1:0] wp;
    logic [CW-1:0] cnt;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;

    // Status is decoded from the registered occupancy only, so stall has no input path.
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

    assign push = f_valid & ~full & ~flush;
    assign pop  = ~empty & d_ready & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else if (flush) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= {f_pc, f_instr};
        end
    end

    always_comb begin
        d_pc    = RESET_PC;
        d_instr = 32'h0000_0000;
        if (!empty) begin
            d_pc    = mem[rp][63:32];
            d_instr = mem[rp][31:0];
        end
    end

    assign stall   = full;
    assign d_valid = ~empty;
    assign count   = cnt;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: vector table, directed corner sequences and a randomized run
// checked against a queue-based model of the fetch/decode contract.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] RPC = 32'h0000_3000;

    logic        clk;
    logic        reset;
    logic        f_valid;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        stall;
    logic        flush;
    logic        d_ready;
    logic        d_valid;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    logic [63:0] model_q[$];

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk     (clk),
        .reset   (reset),
        .f_valid (f_valid),
        .f_pc    (f_pc),
        .f_instr (f_instr),
        .stall   (stall),
        .flush   (flush),
        .d_ready (d_ready),
        .d_valid (d_valid),
        .d_pc    (d_pc),
        .d_instr (d_instr),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fl;
        logic        rdy;
        int          exp_count;
        logic        exp_valid;
        logic        exp_stall;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        int n;
        n = model_q.size();
        chk({tag, " count"},   32'(count),   32'(n));
        chk({tag, " d_valid"}, 32'(d_valid), 32'(n != 0));
        chk({tag, " stall"},   32'(stall),   32'(n == DEPTH));
        chk({tag, " d_pc"},    d_pc,    (n != 0) ? model_q[0][63:32] : RPC);
        chk({tag, " d_instr"}, d_instr, (n != 0) ? model_q[0][31:0]  : 32'h0);
    endtask

    // Apply one cycle of inputs, advance the model by the queue rules, compare after the edge.
    task automatic drive(input logic fv, input logic [31:0] pc, input logic [31:0] instr,
                         input logic fl, input logic rdy, input string tag);
        bit do_push;
        bit do_pop;
        f_valid = fv;
        f_pc    = pc;
        f_instr = instr;
        flush   = fl;
        d_ready = rdy;
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            do_pop  = (model_q.size() != 0) && rdy;
            do_push = fv && (model_q.size() < DEPTH);
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back({pc, instr});
        end
        #1;
        chk_model(tag);
    endtask

    initial begin
        reset   = 1'b0;
        f_valid = 1'b0;
        f_pc    = '0;
        f_instr = '0;
        flush   = 1'b0;
        d_ready = 1'b0;

        vecs[0] = '{1, 32'h3000, 32'h1000_0001, 0, 0, 1, 1, 0, 32'h3000, 32'h1000_0001};
        vecs[1] = '{1, 32'h3004, 32'h1000_0002, 0, 0, 2, 1, 0, 32'h3000, 32'h1000_0001};
        vecs[2] = '{1, 32'h3008, 32'h1000_0003, 0, 0, 3, 1, 0, 32'h3000, 32'h1000_0001};
        vecs[3] = '{1, 32'h300c, 32'h1000_0004, 0, 0, 4, 1, 1, 32'h3000, 32'h1000_0001};
        vecs[4] = '{1, 32'h3010, 32'h1000_0005, 0, 0, 4, 1, 1, 32'h3000, 32'h1000_0001};
        vecs[5] = '{0, 32'h0,    32'h0,         0, 1, 3, 1, 0, 32'h3004, 32'h1000_0002};
        vecs[6] = '{0, 32'h0,    32'h0,         0, 1, 2, 1, 0, 32'h3008, 32'h1000_0003};
        vecs[7] = '{0, 32'h0,    32'h0,         0, 1, 1, 1, 0, 32'h300c, 32'h1000_0004};
        vecs[8] = '{0, 32'h0,    32'h0,         0, 1, 0, 0, 0, 32'h3000, 32'h0};

        // Reset held for 3 cycles with random inputs
        for (int i = 0; i < 3; i++) begin
            f_valid = 1'($urandom);
            f_pc    = $urandom;
            f_instr = $urandom;
            flush   = 1'($urandom);
            d_ready = 1'($urandom);
            @(posedge clk);
            #1;
            chk_model("reset");
        end
        f_valid = 1'b0;
        flush   = 1'b0;
        d_ready = 1'b0;
        reset   = 1'b1;

        // Fill, overflow drop, and drain order
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].fv, vecs[i].pc, vecs[i].instr, vecs[i].fl, vecs[i].rdy, "vec");
            chk("vec count",   32'(count),   32'(vecs[i].exp_count));
            chk("vec d_valid", 32'(d_valid), 32'(vecs[i].exp_valid));
            chk("vec stall",   32'(stall),   32'(vecs[i].exp_stall));
            chk("vec d_pc",    d_pc,         vecs[i].exp_pc);
            chk("vec d_instr", d_instr,      vecs[i].exp_instr);
        end

        // Simultaneous push/pop at count 2 with pointer wrap
        drive(1, 32'h3200, 32'h2000_0000, 0, 0, "wrap pre");
        drive(1, 32'h3204, 32'h2000_0001, 0, 0, "wrap pre");
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h3100 + 32'(4 * i), 32'h3000_0000 + 32'(i), 0, 1, "wrap");
            chk("wrap count", 32'(count), 32'd2);
            if (i >= 2) chk("wrap head", d_pc, 32'h3100 + 32'(4 * (i - 1)));
        end

        // Flush at count 3 with a same-cycle push and ready
        drive(1, 32'h3300, 32'h4000_0000, 0, 0, "flush pre");
        chk("flush pre count", 32'(count), 32'd3);
        drive(1, 32'h4000, 32'h5000_0000, 1, 1, "flush");
        chk("flush count", 32'(count), 32'd0);
        chk("flush d_valid", 32'(d_valid), 32'd0);
        drive(1, 32'h4000, 32'h5000_0000, 0, 0, "post flush");
        chk("post flush head", d_pc, 32'h4000);
        chk("post flush count", 32'(count), 32'd1);

        // Asynchronous reset between edges at count 3
        drive(1, 32'h4004, 32'h5000_0001, 0, 0, "rst pre");
        drive(1, 32'h4008, 32'h5000_0002, 0, 0, "rst pre");
        chk("rst pre count", 32'(count), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        model_q.delete();
        chk_model("async rst");
        f_valid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        drive(1, 32'h3000, 32'h6000_0000, 0, 0, "post rst");
        chk("post rst head", d_pc, 32'h3000);
        chk("post rst valid", 32'(d_valid), 32'd1);

        // Randomized run against the model
        for (int i = 0; i < 500; i++) begin
            drive(1'($urandom_range(0, 9) < 7), $urandom, $urandom,
                  1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) < 5), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the fetch stage (PC register plus instruction memory) and the decode stage of the pipelined CPU. Fetch pushes one {pc, instr} pair per cycle, and decode pops pairs in program order. When the queue is full, `stall` holds the PC register. A branch or jump redirect flushes every buffered entry.

## Interface
- `DEPTH`, default 4: number of entries. Must be a power of two and ≥ 2.
- `RESET_PC`, default 32'h0000_3000: value driven on `d_pc` while the queue is empty.
- `clk` input 1: rising-edge clock.
- `reset` input 1: reset, asynchronous and active-low (0 = reset).
- `f_valid` input 1: fetch presents a valid pair this cycle.
- `f_pc` input 32: address of the fetched instruction.
- `f_instr` input 32: fetched instruction word.
- `stall` output 1: queue full. Connects to the PC register's hold enable (1 = hold PC).
- `flush` input 1: redirect. Discard all entries.
- `d_ready` input 1: decode accepts the head entry this cycle.
- `d_valid` output 1: head entry valid.
- `d_pc` output 32: head entry pc.
- `d_instr` output 32: head entry instruction.
- `count` output $clog2(DEPTH)+1: current occupancy, 0..DEPTH.

## Operation
- Storage is a circular buffer of DEPTH entries × 64 bits, with read pointer `rp`, write pointer `wp` and an occupancy counter. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- `stall` = (count == DEPTH). It is decoded from registered count only and has no combinational path from any input.
- `d_valid` = (count != 0).
- When `d_valid` = 1, `d_pc` and `d_instr` show the entry at `rp`. When `d_valid` = 0, `d_pc` = RESET_PC and `d_instr` = 32'h0000_0000 (nop).
- Push = `f_valid` & !`stall` & !`flush`. On a push, the entry at `wp` is written and `wp` advances.
- Push while full is dropped. The stalled PC re-presents the same pair, so nothing is lost.
- Pop = `d_valid` & `d_ready` & !`flush`. On a pop, `rp` advances.
- Push and pop in the same cycle: both pointers advance and count is unchanged. This is legal at any count from 1 to DEPTH-1.
- At count 0 there is no bypass. A push and `d_ready` in the same cycle is a push only.
- At count DEPTH, a pop with `f_valid` = 1 is a pop only. `stall` drops the next cycle.
- `flush` has priority over push and pop. At the next edge: `rp` = `wp` = 0 and count = 0. The same-cycle `f_valid` pair and `d_ready` are ignored.
- Reset (`reset` = 0), asynchronous and immediate: `rp` = `wp` = 0, count = 0, `stall` = 0, `d_valid` = 0, `d_pc` = RESET_PC, `d_instr` = 0. Storage contents are don't-care.
- Reset asserted mid-operation discards all entries immediately. The first push is accepted at the first rising edge after release.

## Timing
- All state updates on `posedge clk`. No other edges are used except asynchronous reset.
- Push-to-output latency is 1 cycle. A pair pushed at edge k appears on `d_*` with `d_valid` = 1 after edge k, provided it is the head entry.
- Throughput is one push and one pop per cycle sustained.
- `stall` asserts in the cycle after the push that makes count = DEPTH. It deasserts in the cycle after the first pop or flush.
- `flush` takes effect at the same edge it is sampled. `d_valid` = 0 in the following cycle.
- All outputs are glitch-free functions of registers only.

## Test plan
- Reset: hold `reset` = 0 for 3 cycles, with random inputs. Required: `d_valid` = 0, `stall` = 0, count = 0, `d_pc` = 32'h0000_3000, `d_instr` = 0 throughout.
- Fill and stall:
  - Push pc 0x3000, 0x3004, 0x3008, 0x300c (instr 0x1000_0001..4) with `d_ready` = 0.
  - Required: count = 4 and `stall` = 1 after the 4th edge.
  - Then push 0x3010. Required: dropped, count stays 4.
- Drain order: from the full state above, hold `d_ready` = 1 and `f_valid` = 0. Required:
  - `d_pc` reads 0x3000, 0x3004, 0x3008, 0x300c on consecutive cycles.
  - `stall` = 0 from the cycle after the first pop.
  - Then `d_valid` = 0 and `d_pc` = 0x3000.
- Simultaneous push/pop with wrap-around:
  - At count 2, run 10 cycles of push plus pop with pc 0x3100 + 4i.
  - Required: count stays 2, pops arrive in push order, and pointers wrap past entry 3 without loss.
- Flush:
  - At count 3, assert `flush` with `f_valid` = 1 (pc 0x4000) and `d_ready` = 1.
  - Required: count = 0 and `d_valid` = 0 next cycle, and 0x4000 is not stored.
  - A push of 0x4000 on the following cycle appears at the head one cycle later.
- Reset mid-operation:
  - At count 3, drop `reset` asynchronously between edges.
  - Required: `d_valid`/count/`stall` go to 0 before the next edge.
  - After release, push 0x3000. Required: it is the head entry one cycle later.
